// File: rtl/fe_pkg.sv
// Shared types and widths for the instruction fetch front end.
// A queue entry carries an instruction word together with its own PC.
package fe_pkg;

  localparam int INST_W         = 32;
  localparam int LINE_W         = 128;
  localparam int WORDS_PER_LINE = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fq_entry_t;

  function automatic logic [31:0] line_base(input logic [31:0] addr);
    return {addr[31:4], 4'h0};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction queue: up to 4 writes and 1 read per cycle, flush clears it.
// Writes are visible on rd_entry the cycle after the edge; the caller does the space check.
module fetch_queue
  import fe_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [2:0]      wr_cnt,
  input  fq_entry_t       wr_entries [WORDS_PER_LINE],
  input  logic            rd_en,
  input  logic            flush,
  output fq_entry_t       rd_entry,
  output logic [AW:0]     count
);

  fq_entry_t     r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [AW:0]   w_add;
  logic [AW:0]   w_sub;

  assign w_add = wr_en ? (AW+1)'(wr_cnt) : '0;
  assign w_sub = rd_en ? (AW+1)'(1)      : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (wr_en) r_wr_ptr <= r_wr_ptr + AW'(wr_cnt);
      if (rd_en) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + w_add - w_sub;
    end
  end

  // Storage needs no reset: an entry is only observable while r_count covers it.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) begin
      for (int j = 0; j < WORDS_PER_LINE; j++) begin
        if (3'(j) < wr_cnt) r_mem[r_wr_ptr + AW'(j)] <= wr_entries[j];
      end
    end
  end

  assign rd_entry = (r_count == '0) ? '0 : r_mem[r_rd_ptr];
  assign count    = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC, ROM line slicing, queue space check and redirect priority.
// Line pushed in the cycle it is addressed; a line waits (pc holds) until all its words fit.
module fetch_unit
  import fe_pkg::*;
#(
  parameter int          QUEUE_DEPTH = 8,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic [31:0]                  rom_addr,
  input  logic [LINE_W-1:0]            rom_data,
  input  logic                         redirect_valid,
  input  logic [31:0]                  redirect_pc,
  output logic                         inst_valid,
  input  logic                         inst_ready,
  output logic [INST_W-1:0]            inst_data,
  output logic [31:0]                  inst_pc,
  output logic [$clog2(QUEUE_DEPTH):0] queue_count
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  logic [31:0]       r_pc;
  logic [1:0]        w_off;
  logic [2:0]        w_n;
  logic [CW:0]       w_need;
  logic              w_push;
  logic              w_pop;
  logic              w_valid;
  logic [CW-1:0]     w_count;
  logic [1:0]        w_idx [WORDS_PER_LINE];
  logic [INST_W-1:0] w_line_words [WORDS_PER_LINE];
  fq_entry_t         w_wr_entries [WORDS_PER_LINE];
  fq_entry_t         w_rd_entry;

  genvar k;
  generate
    for (k = 0; k < WORDS_PER_LINE; k++) begin : g_words
      assign w_line_words[k] = rom_data[k*INST_W +: INST_W];
    end
  endgenerate

  assign w_off = r_pc[3:2];
  assign w_n   = 3'd4 - {1'b0, w_off};

  // Space is judged on the pre-pop count so a same-cycle pop never lends room.
  assign w_need  = {1'b0, w_count} + (CW+1)'(w_n);
  assign w_push  = !redirect_valid && (w_need <= (CW+1)'(QUEUE_DEPTH));
  assign w_valid = (w_count != '0) && !redirect_valid;
  assign w_pop   = w_valid && inst_ready;

  always_comb begin
    for (int j = 0; j < WORDS_PER_LINE; j++) begin
      w_idx[j]             = w_off + 2'(j);
      w_wr_entries[j].pc   = {r_pc[31:4], w_idx[j], 2'b00};
      w_wr_entries[j].data = w_line_words[w_idx[j]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= {redirect_pc[31:2], 2'b00};
    end else if (w_push) begin
      r_pc <= {r_pc[31:4] + 28'd1, 4'h0};
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (w_push),
    .wr_cnt     (w_n),
    .wr_entries (w_wr_entries),
    .rd_en      (w_pop),
    .flush      (redirect_valid),
    .rd_entry   (w_rd_entry),
    .count      (w_count)
  );

  assign rom_addr    = line_base(r_pc);
  assign inst_valid  = w_valid;
  assign inst_data   = w_rd_entry.data;
  assign inst_pc     = w_rd_entry.pc;
  assign queue_count = w_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural fetch model with a scoreboard of expected PCs,
// plus directed checks of reset, stall, redirect, full-queue and wrap cases.
module tb_fetch_unit;
  import fe_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  rom_addr;
  logic [127:0] rom_data;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         inst_valid;
  logic         inst_ready;
  logic [31:0]  inst_data;
  logic [31:0]  inst_pc;
  logic [3:0]   queue_count;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb [$];
  logic [31:0] m_pc;

  fetch_unit #(.QUEUE_DEPTH(8), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .queue_count    (queue_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] pc);
    return 32'h1000_0000 + (pc >> 2);
  endfunction

  always_comb begin
    rom_data = '0;
    for (int k = 0; k < 4; k++) rom_data[k*32 +: 32] = rom_word(rom_addr) + 32'(k);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    int          off;
    int          n;
    logic        push;
    logic        vld;
    logic        pop;
    logic        redir;
    logic [31:0] rpc;
    @(negedge clk);
    off   = int'(m_pc[3:2]);
    n     = 4 - off;
    redir = redirect_valid;
    rpc   = redirect_pc;
    push  = !redir && (sb.size() + n <= 8);
    vld   = (sb.size() != 0) && !redir;
    pop   = vld && inst_ready;
    check_eq("valid", 32'(inst_valid), 32'(vld));
    check_eq("count", 32'(queue_count), 32'(sb.size()));
    check_eq("rom_addr", rom_addr, {m_pc[31:4], 4'h0});
    if (sb.size() != 0) begin
      check_eq("inst_pc", inst_pc, sb[0]);
      check_eq("inst_data", inst_data, rom_word(sb[0]));
    end else begin
      check_eq("empty_pc", inst_pc, 32'h0);
      check_eq("empty_data", inst_data, 32'h0);
    end
    @(posedge clk);
    if (redir) begin
      sb.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (pop) void'(sb.pop_front());
      if (push) begin
        for (int j = 0; j < n; j++) sb.push_back({m_pc[31:2], 2'b00} + 32'(4*j));
        m_pc = {m_pc[31:4] + 28'd1, 4'h0};
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_valid", 32'(inst_valid), 32'h0);
    check_eq("rst_count", 32'(queue_count), 32'h0);
    check_eq("rst_pc", inst_pc, 32'h0);
    check_eq("rst_data", inst_data, 32'h0);
    check_eq("rst_rom_addr", rom_addr, 32'h0);
    sb.delete();
    m_pc = 32'h0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    rst_n          = 1'b1;
    m_pc           = 32'h0;
    #1;
    do_reset();

    // streaming from reset, consumer always ready
    cycle();
    check_eq("t1_first_valid", 32'(inst_valid), 32'h1);
    check_eq("t1_first_pc", inst_pc, 32'h0);
    check_eq("t1_first_data", inst_data, 32'h1000_0000);
    check_eq("t1_rom_addr", rom_addr, 32'h10);
    repeat (14) cycle();

    // consumer stalled from reset: queue fills, fetch holds
    do_reset();
    inst_ready = 1'b0;
    cycle();
    check_eq("t2_count4", 32'(queue_count), 32'h4);
    cycle();
    check_eq("t2_count8", 32'(queue_count), 32'h8);
    check_eq("t2_rom_hold", rom_addr, 32'h20);
    cycle();
    check_eq("t2_still_full", 32'(queue_count), 32'h8);
    check_eq("t2_rom_hold2", rom_addr, 32'h20);
    check_eq("t2_head_pc", inst_pc, 32'h0);
    inst_ready = 1'b1;
    repeat (20) cycle();

    // redirect to a mid-line address; low bits must be ignored
    redirect_valid = 1'b1;
    redirect_pc    = 32'h2B;
    cycle();
    redirect_valid = 1'b0;
    check_eq("t3_valid_low", 32'(inst_valid), 32'h0);
    check_eq("t3_rom_addr", rom_addr, 32'h20);
    check_eq("t3_flushed", 32'(queue_count), 32'h0);
    cycle();
    check_eq("t3_two_words", 32'(queue_count), 32'h2);
    check_eq("t3_pc28", inst_pc, 32'h28);
    cycle();
    check_eq("t3_pc2c", inst_pc, 32'h2C);
    cycle();
    check_eq("t3_pc30", inst_pc, 32'h30);
    repeat (4) cycle();

    // full queue with ready and redirect in the same cycle
    do_reset();
    inst_ready = 1'b0;
    cycle();
    cycle();
    check_eq("t4_full", 32'(queue_count), 32'h8);
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    cycle();
    redirect_valid = 1'b0;
    check_eq("t4_count0", 32'(queue_count), 32'h0);
    cycle();
    check_eq("t4_pc100", inst_pc, 32'h100);
    check_eq("t4_valid", 32'(inst_valid), 32'h1);
    repeat (6) cycle();

    // count 5 at a line start: no push until a pop frees room, no same-cycle credit
    inst_ready     = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h2C;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    check_eq("t5_count1", 32'(queue_count), 32'h1);
    cycle();
    check_eq("t5_count5", 32'(queue_count), 32'h5);
    check_eq("t5_rom40", rom_addr, 32'h40);
    cycle();
    check_eq("t5_hold5", 32'(queue_count), 32'h5);
    check_eq("t5_hold40", rom_addr, 32'h40);
    inst_ready = 1'b1;
    cycle();
    check_eq("t5_count4", 32'(queue_count), 32'h4);
    check_eq("t5_rom40b", rom_addr, 32'h40);
    inst_ready = 1'b0;
    cycle();
    check_eq("t5_count8", 32'(queue_count), 32'h8);
    check_eq("t5_rom50", rom_addr, 32'h50);
    inst_ready = 1'b1;
    repeat (12) cycle();

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    check_eq("wrap_rom0", rom_addr, 32'h0);
    check_eq("wrap_pc", inst_pc, 32'hFFFF_FFF8);
    repeat (8) cycle();

    // asynchronous reset in the middle of a stream
    repeat (3) cycle();
    #2;
    do_reset();
    cycle();
    check_eq("t6_restart_pc", inst_pc, 32'h0);
    check_eq("t6_restart_valid", 32'(inst_valid), 32'h1);
    repeat (10) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
